// File: rtl/snn_pkg.sv
// Shared widths, network sizes and FSM encoding for the
// spiking ECG beat classifier.
package snn_pkg;

    localparam int N_IN       = 16;
    localparam int N_HID      = 8;
    localparam int N_OUT      = 6;
    localparam int T_STEPS    = 64;
    localparam int P_WIDTH    = 8;
    localparam int W_WIDTH    = 8;
    localparam int V_WIDTH    = 16;
    localparam int LEAK_SHIFT = 4;

    localparam logic signed [V_WIDTH-1:0] THRESH = 16'sd64;

    typedef enum logic [2:0] {
        IDLE,
        HID_ACC,
        HID_FIRE,
        OUT_ACC,
        OUT_FIRE,
        DONE
    } state_t;

endpackage

// File: rtl/snn_lif_neuron.sv
// Leaky integrate-and-fire neuron with saturating accumulate
// and its own weight table indexed by presynaptic neuron.
import snn_pkg::*;

module snn_lif_neuron #(
    parameter  int FAN_IN = 16,
    localparam int AW     = $clog2(FAN_IN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          acc,
    input  logic [AW-1:0] idx,
    input  logic          fire,
    output logic          spike
);

    localparam logic signed [V_WIDTH-1:0] V_MAX =
        {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] V_MIN =
        {1'b1, {(V_WIDTH-1){1'b0}}};

    logic signed [W_WIDTH-1:0] w;
    logic signed [V_WIDTH-1:0] v;
    logic signed [V_WIDTH-1:0] v_acc;
    logic signed [V_WIDTH-1:0] v_leak;
    logic signed [V_WIDTH:0]   sum;
    logic                      over;

    snn_weight_rom #(.DEPTH(FAN_IN)) ROM0 (
        .addr(idx),
        .data(w)
    );

    // One guard bit detects signed overflow of the sum.
    assign sum = {v[V_WIDTH-1], v}
               + {{(V_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w};

    always_comb begin
        v_acc = sum[V_WIDTH-1:0];
        if (sum[V_WIDTH] != sum[V_WIDTH-1])
            v_acc = sum[V_WIDTH] ? V_MIN : V_MAX;
    end

    assign v_leak = v - (v >>> LEAK_SHIFT);
    assign over   = (v >= THRESH);
    assign spike  = fire && over;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            v <= '0;
        else if (clear)
            v <= '0;
        else if (acc)
            v <= v_acc;
        else if (fire)
            v <= (over || v_leak[V_WIDTH-1]) ? '0 : v_leak;
    end

endmodule

// File: rtl/snn_weight_rom.sv
// Fixed weight table for one neuron; contents are preloaded
// from outside and never written by the design.
import snn_pkg::*;

module snn_weight_rom #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]      addr,
    output logic [W_WIDTH-1:0] data
);

    logic [W_WIDTH-1:0] mem [0:DEPTH-1];

    assign data = mem[addr];

endmodule

// File: rtl/snn_ecg_classifier.sv
// Two-layer spiking classifier: rate-coded inputs, 8 hidden and
// 6 output LIF neurons, argmax over paired output spike counts.
import snn_pkg::*;

module snn_ecg_classifier (
    input  logic       clk,
    input  logic       resetn,
    output logic [1:0] output_class,
    output logic       no_spike,
    output logic       end_process
);

    logic [P_WIDTH-1:0] in_period [0:N_IN-1];
    logic [P_WIDTH-1:0] in_cnt    [N_IN];
    logic [7:0]         spk_cnt   [N_OUT];

    logic [N_IN-1:0]  in_spk;
    logic [N_HID-1:0] hid_spk;
    logic [N_HID-1:0] hid_hit;
    logic [N_OUT-1:0] out_hit;

    state_t     state, state_nx;
    logic [3:0] k;
    logic [5:0] step;
    logic       clr, hid_acc, hid_fire, out_acc, out_fire;
    logic       step_start;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = HID_ACC;
            HID_ACC:  if (k == 4'(N_IN-1))  state_nx = HID_FIRE;
            HID_FIRE: state_nx = OUT_ACC;
            OUT_ACC:  if (k == 4'(N_HID-1)) state_nx = OUT_FIRE;
            OUT_FIRE: state_nx = (step == 6'(T_STEPS-1)) ? DONE
                                                         : HID_ACC;
            DONE:     state_nx = DONE;
            default:  state_nx = IDLE;
        endcase
    end

    assign clr        = (state == IDLE);
    assign hid_acc    = (state == HID_ACC) && in_spk[k];
    assign hid_fire   = (state == HID_FIRE);
    assign out_acc    = (state == OUT_ACC) && hid_spk[k[2:0]];
    assign out_fire   = (state == OUT_FIRE);
    assign step_start = (state_nx == HID_ACC) && (state != HID_ACC);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            k       <= '0;
            step    <= '0;
            in_spk  <= '0;
            hid_spk <= '0;
            for (int i = 0; i < N_IN; i++)  in_cnt[i]  <= '0;
            for (int o = 0; o < N_OUT; o++) spk_cnt[o] <= '0;
        end else begin
            if ((state == HID_ACC && k != 4'(N_IN-1)) ||
                (state == OUT_ACC && k != 4'(N_HID-1)))
                k <= k + 4'd1;
            else
                k <= '0;
            if (clr)      step <= '0;
            if (out_fire) step <= step + 6'd1;
            // Each input's spike for the step is latched once here.
            if (step_start) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (in_period[i] != '0 &&
                        in_cnt[i] == in_period[i] - 8'd1) begin
                        in_spk[i] <= 1'b1;
                        in_cnt[i] <= '0;
                    end else begin
                        in_spk[i] <= 1'b0;
                        in_cnt[i] <= in_cnt[i] + 8'd1;
                    end
                end
            end
            if (hid_fire) hid_spk <= hid_hit;
            for (int o = 0; o < N_OUT; o++)
                if (out_fire && out_hit[o] && spk_cnt[o] != 8'hff)
                    spk_cnt[o] <= spk_cnt[o] + 8'd1;
        end
    end

    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid0 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[0]));
    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid1 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[1]));
    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid2 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[2]));
    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid3 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[3]));
    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid4 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[4]));
    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid5 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[5]));
    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid6 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[6]));
    snn_lif_neuron #(.FAN_IN(N_IN)) neuron_hid7 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(hid_acc), .idx(k),
        .fire(hid_fire), .spike(hid_hit[7]));

    snn_lif_neuron #(.FAN_IN(N_HID)) neuron_out0 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(out_acc), .idx(k[2:0]),
        .fire(out_fire), .spike(out_hit[0]));
    snn_lif_neuron #(.FAN_IN(N_HID)) neuron_out1 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(out_acc), .idx(k[2:0]),
        .fire(out_fire), .spike(out_hit[1]));
    snn_lif_neuron #(.FAN_IN(N_HID)) neuron_out2 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(out_acc), .idx(k[2:0]),
        .fire(out_fire), .spike(out_hit[2]));
    snn_lif_neuron #(.FAN_IN(N_HID)) neuron_out3 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(out_acc), .idx(k[2:0]),
        .fire(out_fire), .spike(out_hit[3]));
    snn_lif_neuron #(.FAN_IN(N_HID)) neuron_out4 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(out_acc), .idx(k[2:0]),
        .fire(out_fire), .spike(out_hit[4]));
    snn_lif_neuron #(.FAN_IN(N_HID)) neuron_out5 (.clk(clk),
        .rst(resetn), .clear(clr), .acc(out_acc), .idx(k[2:0]),
        .fire(out_fire), .spike(out_hit[5]));

    logic [8:0] s0, s1, s2, best;
    logic [1:0] cls;
    logic       silent;

    assign s0 = {1'b0, spk_cnt[0]} + {1'b0, spk_cnt[1]};
    assign s1 = {1'b0, spk_cnt[2]} + {1'b0, spk_cnt[3]};
    assign s2 = {1'b0, spk_cnt[4]} + {1'b0, spk_cnt[5]};

    // Strict compares keep ties on the lower class index.
    always_comb begin
        best = s0;
        cls  = 2'd0;
        if (s1 > best) begin
            best = s1;
            cls  = 2'd1;
        end
        if (s2 > best) cls = 2'd2;
    end

    assign silent       = (s0 == '0) && (s1 == '0) && (s2 == '0);
    assign end_process  = (state == DONE);
    assign no_spike     = end_process && silent;
    assign output_class = end_process ? cls : 2'd0;

endmodule

// File: tb/tb_snn_ecg_classifier.sv
// Directed bench for the spiking ECG classifier: timing, class
// decisions, ties, leak dynamics, stickiness and mid-run reset.
import snn_pkg::*;

module tb_snn_ecg_classifier;

    localparam int RUN_CYC = 1 + 64 * 26;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [1:0] output_class;
    logic       no_spike;
    logic       end_process;

    int checks = 0;
    int failures = 0;

    snn_ecg_classifier dut (
        .clk(clk),
        .resetn(resetn),
        .output_class(output_class),
        .no_spike(no_spike),
        .end_process(end_process)
    );

    always #5 clk = ~clk;

    task automatic set_periods(input logic [7:0] p);
        for (int i = 0; i < 16; i++) dut.in_period[i] = p;
    endtask

    task automatic set_hid(input int n, input logic [7:0] w);
        for (int j = 0; j < 16; j++)
            case (n)
                0: dut.neuron_hid0.ROM0.mem[j] = w;
                1: dut.neuron_hid1.ROM0.mem[j] = w;
                2: dut.neuron_hid2.ROM0.mem[j] = w;
                3: dut.neuron_hid3.ROM0.mem[j] = w;
                4: dut.neuron_hid4.ROM0.mem[j] = w;
                5: dut.neuron_hid5.ROM0.mem[j] = w;
                6: dut.neuron_hid6.ROM0.mem[j] = w;
                default: dut.neuron_hid7.ROM0.mem[j] = w;
            endcase
    endtask

    task automatic set_out(input int n, input logic [7:0] w);
        for (int j = 0; j < 8; j++)
            case (n)
                0: dut.neuron_out0.ROM0.mem[j] = w;
                1: dut.neuron_out1.ROM0.mem[j] = w;
                2: dut.neuron_out2.ROM0.mem[j] = w;
                3: dut.neuron_out3.ROM0.mem[j] = w;
                4: dut.neuron_out4.ROM0.mem[j] = w;
                default: dut.neuron_out5.ROM0.mem[j] = w;
            endcase
    endtask

    task automatic set_hid_all(input logic [7:0] w);
        for (int n = 0; n < 8; n++) set_hid(n, w);
    endtask

    task automatic set_outs(input logic [7:0] w0, w1, w2,
                            input logic [7:0] w3, w4, w5);
        set_out(0, w0); set_out(1, w1); set_out(2, w2);
        set_out(3, w3); set_out(4, w4); set_out(5, w5);
    endtask

    task automatic start_run();
        @(negedge clk) resetn = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!end_process && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_run(input string name, input int n,
                             input logic [1:0] ecls,
                             input logic ens);
        checks++;
        if (n !== RUN_CYC) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, want %0d",
                     name, n, RUN_CYC);
        end
        checks++;
        if (output_class !== ecls || no_spike !== ens) begin
            failures++;
            $display("FAIL %s result: class=%0d no_spike=%0b, want %0d/%0b",
                     name, output_class, no_spike, ecls, ens);
        end
    endtask

    task automatic test_reset();
        int n;
        set_periods(8'd0);
        set_hid_all(8'd8);
        set_outs(8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8);
        @(negedge clk) resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({end_process, output_class, no_spike} !== 4'b0) begin
                failures++;
                $display("FAIL reset_outs: end=%0b class=%0d ns=%0b, want 0",
                         end_process, output_class, no_spike);
            end
        end
        @(negedge clk) resetn = 1'b0;
        wait_done(n);
        check_run("all_zero_periods", n, 2'd0, 1'b1);
    endtask

    task automatic test_class1();
        int n;
        set_periods(8'd1);
        set_hid_all(8'd8);
        set_outs(8'hf8, 8'hf8, 8'd8, 8'd8, 8'd1, 8'd1);
        start_run();
        wait_done(n);
        check_run("class1", n, 2'd1, 1'b0);
    endtask

    task automatic test_tie();
        int n;
        set_outs(8'd16, 8'hf0, 8'hf0, 8'hf0, 8'd16, 8'hf0);
        start_run();
        wait_done(n);
        check_run("tie_0_2", n, 2'd0, 1'b0);
    endtask

    task automatic test_class2_sticky();
        int n;
        set_outs(8'd16, 8'hf0, 8'hf0, 8'hf0, 8'd16, 8'd16);
        start_run();
        wait_done(n);
        check_run("class2", n, 2'd2, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (end_process !== 1'b1 || output_class !== 2'd2) begin
            failures++;
            $display("FAIL sticky: end=%0b class=%0d, want 1/2",
                     end_process, output_class);
        end
    endtask

    task automatic test_leak();
        int v = 0;
        logic spk;
        int cyc;
        set_periods(8'd0);
        dut.in_period[0] = 8'd1;
        set_hid_all(8'd0);
        dut.neuron_hid0.ROM0.mem[0] = 8'd20;
        set_outs(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        start_run();
        for (int s = 0; s < 9; s++) begin
            v = v + 20;
            spk = (v >= 64);
            if (spk) v = 0;
            else begin
                v = v - (v >>> 4);
                if (v < 0) v = 0;
            end
            cyc = 0;
            while (dut.state != HID_FIRE && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            @(posedge clk);
            #1;
            checks++;
            if (cyc >= 40 || dut.neuron_hid0.v !== 16'(v) ||
                dut.hid_spk[0] !== spk) begin
                failures++;
                $display("FAIL leak step%0d: v=%0d spk=%0b, want %0d/%0b",
                         s, dut.neuron_hid0.v, dut.hid_spk[0], v, spk);
            end
        end
    endtask

    task automatic test_midrun_reset();
        int n;
        set_periods(8'd1);
        set_hid_all(8'd8);
        set_outs(8'hf8, 8'hf8, 8'd8, 8'd8, 8'd1, 8'd1);
        start_run();
        repeat (1 + 10 * 26) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        #1;
        checks++;
        if (dut.state !== IDLE || dut.spk_cnt[2] !== 8'd0 ||
            dut.neuron_hid0.v !== 16'd0 || end_process !== 1'b0) begin
            failures++;
            $display("FAIL midrun_clear: state=%0d cnt2=%0d v=%0d end=%0b",
                     dut.state, dut.spk_cnt[2], dut.neuron_hid0.v,
                     end_process);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        wait_done(n);
        check_run("rerun", n, 2'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_class1();
        test_tie();
        test_class2_sticky();
        test_leak();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
